// File: rtl/inst_fetch_pkg.sv
// ---------------------------------------------------------------------------
// inst_fetch_pkg : shared CPU constants and fetch FSM encoding. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package inst_fetch_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

endpackage : inst_fetch_pkg

`default_nettype wire

// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch : single-outstanding I-cache fetch with a one-entry buffer. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module inst_fetch
  import inst_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_if,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  output logic        icache_req,
  output logic [31:0] icache_addr,
  input  logic        icache_ready,
  input  logic        icache_rvalid,
  input  logic [31:0] icache_rdata,
  output logic [31:0] if_inst,
  output logic [31:0] if_cur_instaddress,
  output logic [31:0] if_next_instaddress
);

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;
  logic         r_run;
  logic [31:0]  r_pc;
  logic [31:0]  r_buf_inst;
  logic [31:0]  r_buf_addr;
  logic         r_buf_valid;

  logic         w_consume;
  logic         w_accept;
  logic         w_fill;
  logic [31:0]  w_redir_pc;

  assign w_consume  = r_buf_valid & ~stall_if;
  assign w_redir_pc = redirect_addr & ~32'h3;
  assign w_fill     = (r_state == ST_WAIT) & icache_rvalid & ~redirect_valid;

  // r_run keeps the first request off until the first edge after reset release.
  assign icache_req  = r_run & (r_state == ST_REQ) & (~r_buf_valid | w_consume);
  assign icache_addr = r_pc;
  assign w_accept    = icache_req & icache_ready;

  assign if_inst             = r_buf_valid ? r_buf_inst : NOP_INST;
  assign if_cur_instaddress  = r_buf_valid ? r_buf_addr : 32'h0000_0000;
  assign if_next_instaddress = (r_buf_valid ? r_buf_addr : 32'h0000_0000) + 32'd4;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_REQ: begin
        if (w_accept) w_state_nxt = redirect_valid ? ST_DROP : ST_WAIT;
      end
      ST_WAIT: begin
        if (redirect_valid)     w_state_nxt = icache_rvalid ? ST_REQ : ST_DROP;
        else if (icache_rvalid) w_state_nxt = ST_REQ;
      end
      ST_DROP: begin
        // A stale response arriving alongside a further redirect still retires it.
        if (icache_rvalid) w_state_nxt = ST_REQ;
      end
      default: w_state_nxt = ST_REQ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_REQ;
      r_run       <= 1'b0;
      r_pc        <= RESET_PC;
      r_buf_inst  <= NOP_INST;
      r_buf_addr  <= 32'h0000_0000;
      r_buf_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_run   <= 1'b1;

      if (redirect_valid) r_pc <= w_redir_pc;
      else if (w_fill)    r_pc <= r_pc + 32'd4;

      if (redirect_valid)  r_buf_valid <= 1'b0;
      else if (w_fill)     r_buf_valid <= 1'b1;
      else if (w_consume)  r_buf_valid <= 1'b0;

      if (w_fill) begin
        r_buf_inst <= icache_rdata;
        r_buf_addr <= r_pc;
      end
    end
  end

endmodule : inst_fetch

`default_nettype wire

// File: tb/tb_inst_fetch.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch : directed bench with a transaction-level fetch model. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_if = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_addr = '0;
  logic        icache_req;
  logic [31:0] icache_addr;
  logic        icache_ready = 1'b0;
  logic        icache_rvalid = 1'b0;
  logic [31:0] icache_rdata = '0;
  logic [31:0] if_inst;
  logic [31:0] if_cur_instaddress;
  logic [31:0] if_next_instaddress;

  int n_checks = 0;
  int n_errors = 0;

  inst_fetch dut (
    .clk                 (clk),
    .rst                 (rst),
    .stall_if            (stall_if),
    .redirect_valid      (redirect_valid),
    .redirect_addr       (redirect_addr),
    .icache_req          (icache_req),
    .icache_addr         (icache_addr),
    .icache_ready        (icache_ready),
    .icache_rvalid       (icache_rvalid),
    .icache_rdata        (icache_rdata),
    .if_inst             (if_inst),
    .if_cur_instaddress  (if_cur_instaddress),
    .if_next_instaddress (if_next_instaddress)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: pc, an optional held instruction, and the status of the single
  // outstanding cache transaction (none / live / stale).
  localparam int O_NONE = 0, O_LIVE = 1, O_STALE = 2;
  logic [31:0] m_pc;
  logic        m_has;
  logic [31:0] m_inst, m_addr;
  int          m_out;
  logic        m_run;

  function automatic logic m_req();
    return m_run && (m_out == O_NONE) && (!m_has || !stall_if);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc = 32'h0; m_has = 1'b0; m_inst = 32'h0; m_addr = 32'h0;
      m_out = O_NONE; m_run = 1'b0;
    end else begin
      logic accept;
      accept = m_req() && icache_ready;
      if (m_has && !stall_if) m_has = 1'b0;
      if (redirect_valid) begin
        m_pc  = {redirect_addr[31:2], 2'b00};
        m_has = 1'b0;
        if (m_out == O_NONE) m_out = accept ? O_STALE : O_NONE;
        else                 m_out = icache_rvalid ? O_NONE : O_STALE;
      end else if (m_out == O_LIVE && icache_rvalid) begin
        m_inst = icache_rdata; m_addr = m_pc; m_has = 1'b1;
        m_pc   = m_pc + 32'd4; m_out = O_NONE;
      end else if (m_out == O_STALE && icache_rvalid) begin
        m_out = O_NONE;
      end else if (m_out == O_NONE && accept) begin
        m_out = O_LIVE;
      end
      m_run = 1'b1;
    end
  end

  always @(negedge clk) begin
    chk("cmp_req", {31'b0, icache_req}, {31'b0, m_req()});
    if (m_req()) chk("cmp_addr", icache_addr, m_pc);
    chk("cmp_inst", if_inst, m_has ? m_inst : 32'h0);
    chk("cmp_cur",  if_cur_instaddress, m_has ? m_addr : 32'h0);
    chk("cmp_next", if_next_instaddress, (m_has ? m_addr : 32'h0) + 32'd4);
  end

  task automatic drive(input logic st, input logic rdy, input logic rv,
                       input logic [31:0] rd, input logic rdir, input logic [31:0] ra);
    stall_if = st; icache_ready = rdy; icache_rvalid = rv; icache_rdata = rd;
    redirect_valid = rdir; redirect_addr = ra;
    #1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk_out(input string nm, input logic [31:0] i, input logic [31:0] c,
                         input logic [31:0] n);
    chk({nm, "_inst"}, if_inst, i);
    chk({nm, "_cur"},  if_cur_instaddress, c);
    chk({nm, "_next"}, if_next_instaddress, n);
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) tick();
    chk_out("rst", 32'h0, 32'h0, 32'h4);
    chk("rst_req", {31'b0, icache_req}, 32'h0);
    rst = 1'b0;
    #1;
    chk("rel_req", {31'b0, icache_req}, 32'h0);
    tick();

    // First fetch at 0x0
    drive(0, 1, 0, 0, 0, 0);
    chk("f0_req", {31'b0, icache_req}, 32'h1);
    chk("f0_addr", icache_addr, 32'h0);
    tick();
    drive(0, 0, 1, 32'h2008_0005, 0, 0);
    chk("f0_wait_req", {31'b0, icache_req}, 32'h0);
    tick();

    // Buffer full, stalled for 3 cycles
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 0, 0, 0, 0);
      chk_out("stall", 32'h2008_0005, 32'h0, 32'h4);
      chk("stall_req", {31'b0, icache_req}, 32'h0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    chk("unstall_req", {31'b0, icache_req}, 32'h1);
    chk("unstall_addr", icache_addr, 32'h4);
    tick();
    drive(0, 1, 0, 0, 0, 0);
    chk_out("consumed", 32'h0, 32'h0, 32'h4);
    tick();

    // Redirect during WAIT, stale data next cycle
    drive(0, 0, 0, 0, 1, 32'h0000_0100);
    tick();
    drive(0, 0, 1, 32'hDEAD_BEEF, 0, 0);
    chk("drop_req", {31'b0, icache_req}, 32'h0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk_out("dropped", 32'h0, 32'h0, 32'h4);
    chk("post_drop_addr", icache_addr, 32'h100);
    drive(0, 1, 0, 0, 0, 0);
    tick();

    // Redirect coincident with rvalid: no DROP cycle
    drive(0, 0, 1, 32'h1111_1111, 1, 32'h0000_0103);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk_out("coinc", 32'h0, 32'h0, 32'h4);
    chk("coinc_req", {31'b0, icache_req}, 32'h1);
    chk("coinc_addr", icache_addr, 32'h100);
    drive(0, 1, 0, 0, 0, 0); tick();
    drive(0, 0, 1, 32'h00A0_0093, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0);
    chk_out("f100", 32'h00A0_0093, 32'h100, 32'h104);
    chk("f100_addr", icache_addr, 32'h104);

    // Wrap at 0xFFFFFFFC (redirect in REQ without acceptance)
    drive(0, 0, 0, 0, 1, 32'hFFFF_FFFC); tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("wrap_addr", icache_addr, 32'hFFFF_FFFC);
    drive(0, 1, 0, 0, 0, 0); tick();
    drive(0, 0, 1, 32'h1234_5678, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0);
    chk_out("wrap", 32'h1234_5678, 32'hFFFF_FFFC, 32'h0);
    chk("wrap_next_addr", icache_addr, 32'h0);

    // Redirect with accepted request -> DROP; second redirect inside DROP
    drive(0, 1, 0, 0, 1, 32'h0000_0200); tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("req_drop_req", {31'b0, icache_req}, 32'h0);
    tick();
    drive(0, 0, 0, 0, 1, 32'h0000_0300); tick();
    drive(0, 0, 1, 32'h0000_0BAD, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0);
    chk_out("drop2", 32'h0, 32'h0, 32'h4);
    chk("drop2_addr", icache_addr, 32'h300);

    // Protocol-error rvalid in REQ is ignored
    drive(0, 0, 1, 32'h0000_CAFE, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0);
    chk_out("perr", 32'h0, 32'h0, 32'h4);

    // Fill buffer, then asynchronous reset mid-WAIT
    drive(0, 1, 0, 0, 0, 0); tick();
    drive(1, 0, 1, 32'h0000_0777, 0, 0); tick();
    drive(1, 1, 0, 0, 0, 0);
    chk_out("pre_rst", 32'h0000_0777, 32'h300, 32'h304);
    drive(0, 1, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk_out("async_rst", 32'h0, 32'h0, 32'h4);
    chk("async_rst_req", {31'b0, icache_req}, 32'h0);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rel2_req", {31'b0, icache_req}, 32'h0);
    tick();
    chk("rel2_req_up", {31'b0, icache_req}, 32'h1);
    chk("rel2_addr", icache_addr, 32'h0);
    drive(0, 1, 0, 0, 0, 0); tick();
    drive(0, 0, 1, 32'h0040_0013, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0); tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_inst_fetch

`default_nettype wire
